inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; power of two, minimum 4.
REQ-002 Parameter STALL_FREE, default 2, free-entry count at or below which fetch is stalled; covers Icache responses already in flight.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 redir_i  input  1  flush from writeback; discards all queue contents.
REQ-006 ic_valid_i  input  1  Icache response valid; push request.
REQ-007 ic_pc_i  input  64  PC of the response.
REQ-008 ic_inst_i  input  32  instruction word of the response.
REQ-009 stall_f0_o  output  1  stall to fetch stage 0.
REQ-010 iq_valid_o  input-side pair: output  1  head entry valid toward decode.
REQ-011 iq_pc_o  output  64  head entry PC.
REQ-012 iq_inst_o  output  32  head entry instruction.
REQ-013 dec_ready_i  input  1  decode accepts head this cycle.
REQ-014 ovf_o  output  1  one-cycle pulse on a push dropped because the queue is full.

Function
REQ-015 Storage: circular buffer of DEPTH entries {pc[63:0], inst[31:0]}; write pointer, read pointer, and count of width log2(DEPTH)+1.
REQ-016 Push occurs when ic_valid_i=1, redir_i=0, and count<DEPTH; the entry is written at the write pointer, and the write pointer increments modulo DEPTH.
REQ-017 Pop occurs when iq_valid_o=1, dec_ready_i=1, and redir_i=0; the read pointer increments modulo DEPTH.
REQ-018 iq_valid_o = (count!=0); iq_pc_o/iq_inst_o are combinational reads of the entry at the read pointer, with zero added latency from storage.
REQ-019 Push-to-output latency: an entry pushed in cycle N is visible on iq_* in cycle N+1 when the queue was empty.
REQ-020 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-021 Simultaneous push and pop at count=DEPTH: the pop is not considered; the push is dropped (full check uses registered count) and ovf_o pulses.
REQ-022 Pop with count=0 is impossible because iq_valid_o=0; dec_ready_i is ignored in that case.
REQ-023 Push with count=DEPTH: the entry is discarded, no state changes, and ovf_o=1 for that cycle.
REQ-024 stall_f0_o = ((DEPTH - count) <= STALL_FREE) | redir_i is combinational from registered count; stall is held on redirect so fetch restarts cleanly the following cycle.
REQ-025 redir_i=1: next cycle count=0 and both pointers=0; any same-cycle push and pop are suppressed.
REQ-026 Pointer wrap: the pointer after DEPTH-1 is 0; ordering is strictly FIFO across the wrap.

Reset
REQ-027 When rst_n=0 at a rising edge: count=0, pointers=0, and ovf_o=0; therefore iq_valid_o=0 and stall_f0_o=0 (given STALL_FREE<DEPTH).
REQ-028 Entry storage is not reset; iq_pc_o/iq_inst_o are don't-care while iq_valid_o=0.
REQ-029 Reset asserted mid-operation discards all entries exactly as a redirect does, with reset taking priority over redir_i.

Structure
REQ-030 The shared frontend package holds the entry struct (pc, inst), PC_W=64, INST_W=32, and default DEPTH/STALL_FREE.
REQ-031 One sub-module, iq_ram (DEPTH x 96 storage, one synchronous write port, one asynchronous read port); pointer and count logic lives in inst_queue.

Verification
REQ-032 Reset, then push pc 0x1000, 0x1004, 0x1008 with dec_ready_i=0 -> count=3, iq_pc_o=0x1000, stall_f0_o=0.
REQ-033 From empty, push 6 entries with dec_ready_i=0 (DEPTH=8, STALL_FREE=2) -> stall_f0_o=1 once count=6; 2 further pushes -> count=8; a 9th push -> ovf_o pulses and count stays 8.
REQ-034 With count=4, push and pop in the same cycle -> count stays 4, iq_pc_o advances to the next PC.
REQ-035 Run 20 pushes and pops through DEPTH=8 -> PCs emerge in order 0x2000 to 0x204C across the pointer wrap.
REQ-036 With count=5, redir_i=1 together with ic_valid_i=1 and dec_ready_i=1 -> next cycle count=0, iq_valid_o=0, and the incoming entry is absent.
REQ-037 Drive rst_n=0 for one edge while count=7 -> next cycle iq_valid_o=0, stall_f0_o=0, ovf_o=0.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared frontend definitions for the instruction queue: entry layout, widths and
// default sizing.
package inst_queue_pkg;

  localparam int PC_W           = 64;
  localparam int INST_W         = 32;
  localparam int ENTRY_W        = PC_W + INST_W;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_STALL_FREE = 2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Icache-response push side and decode pop side of the instruction queue,
// bundled so the queue and its neighbours share one connection point.
interface inst_queue_if;
  import inst_queue_pkg::*;

  logic              ic_valid_i;
  logic [PC_W-1:0]   ic_pc_i;
  logic [INST_W-1:0] ic_inst_i;
  logic              iq_valid_o;
  logic [PC_W-1:0]   iq_pc_o;
  logic [INST_W-1:0] iq_inst_o;
  logic              dec_ready_i;

  modport slave (
    input  ic_valid_i, ic_pc_i, ic_inst_i, dec_ready_i,
    output iq_valid_o, iq_pc_o, iq_inst_o
  );

  modport master (
    output ic_valid_i, ic_pc_i, ic_inst_i, dec_ready_i,
    input  iq_valid_o, iq_pc_o, iq_inst_o
  );

endinterface

// File: rtl/inst_queue_ram.sv
// DEPTH x 96-bit entry storage: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module iq_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  iq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output iq_entry_t     rdata
);

  iq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between the Icache and decode: a circular FIFO with an
// early fetch stall, overflow reporting and a full flush on redirect.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STALL_FREE = DEF_STALL_FREE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redir_i,
  output logic        stall_f0_o,
  output logic        ovf_o,
  inst_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] free_cnt;
  logic          full, push, pop;
  iq_entry_t     wr_entry, rd_entry;

  // Full is judged on the registered count, so a same-cycle pop never makes room.
  assign full     = (cnt_q == CW'(DEPTH));
  assign push     = bus.ic_valid_i & ~redir_i & ~full;
  assign pop      = (cnt_q != '0) & bus.dec_ready_i & ~redir_i;
  assign free_cnt = CW'(DEPTH) - cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (redir_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      wptr_d = wptr_q + AW'(push);
      rptr_d = rptr_q + AW'(pop);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wr_entry.pc   = bus.ic_pc_i;
  assign wr_entry.inst = bus.ic_inst_i;

  iq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push & rst_n),
    .waddr (wptr_q),
    .wdata (wr_entry),
    .raddr (rptr_q),
    .rdata (rd_entry)
  );

  assign bus.iq_valid_o = (cnt_q != '0);
  assign bus.iq_pc_o    = rd_entry.pc;
  assign bus.iq_inst_o  = rd_entry.inst;

  // Stall leaves STALL_FREE slots for Icache responses already in flight.
  assign stall_f0_o = (free_cnt <= CW'(STALL_FREE)) | redir_i;
  assign ovf_o      = rst_n & bus.ic_valid_i & ~redir_i & full;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus pushes expected entries into a model
// FIFO, a negedge monitor compares the DUT head, valid, stall and overflow.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH      = 8;
  localparam int STALL_FREE = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic redir;
  logic stall;
  logic ovf;

  inst_queue_if bus ();

  inst_queue #(
    .DEPTH      (DEPTH),
    .STALL_FREE (STALL_FREE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .redir_i    (redir),
    .stall_f0_o (stall),
    .ovf_o      (ovf),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  iq_entry_t exp_q[$];
  int        checks = 0;
  int        errors = 0;
  bit        chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the expected entry is queued only if the model accepts it.
  task automatic step(input bit v, input logic [63:0] pc, input bit rdy,
                      input bit rd, input bit rn);
    iq_entry_t e;
    bit        acc;
    e.pc   = pc;
    e.inst = $urandom;
    bus.ic_valid_i  = v;
    bus.ic_pc_i     = pc;
    bus.ic_inst_i   = e.inst;
    bus.dec_ready_i = rdy;
    redir           = rd;
    rst_n           = rn;
    acc = v && !rd && rn && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (!rn || rd) exp_q.delete();
    else if (acc) exp_q.push_back(e);
    chk_en = 1'b1;
    #1;
  endtask

  // Monitor: compares against the model state for the current cycle, then retires the head.
  always @(negedge clk) begin
    int sz;
    if (chk_en) begin
      sz = exp_q.size();
      chk("iq_valid", 64'(bus.iq_valid_o), 64'(sz != 0));
      if (sz != 0 && bus.iq_valid_o === 1'b1) begin
        chk("iq_pc", bus.iq_pc_o, exp_q[0].pc);
        chk("iq_inst", 64'(bus.iq_inst_o), 64'(exp_q[0].inst));
      end
      chk("stall_f0", 64'(stall), 64'(((DEPTH - sz) <= STALL_FREE) || redir));
      chk("ovf", 64'(ovf), 64'(bus.ic_valid_i && !redir && rst_n && sz == DEPTH));
      if (sz != 0 && bus.dec_ready_i && !redir && rst_n) void'(exp_q.pop_front());
    end
  end

  initial begin
    // Reset
    step(0, 64'h0, 0, 0, 0);
    step(0, 64'h0, 0, 0, 0);
    step(0, 64'h0, 0, 0, 1);

    // Three pushes held at the head, then drain
    for (int i = 0; i < 3; i++) step(1, 64'h1000 + 64'(4 * i), 0, 0, 1);
    step(0, 64'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 64'h0, 1, 0, 1);

    // Fill to stall, to full, then overflow
    for (int i = 0; i < 9; i++) step(1, 64'h3000 + 64'(4 * i), 0, 0, 1);
    step(0, 64'h0, 0, 0, 1);

    // Drain to 5, then redirect with a colliding push and pop
    for (int i = 0; i < 3; i++) step(0, 64'h0, 1, 0, 1);
    step(1, 64'h3100, 1, 1, 1);
    step(0, 64'h0, 1, 0, 1);

    // Count of 4, then simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1, 64'h4000 + 64'(4 * i), 0, 0, 1);
    step(1, 64'h4010, 1, 0, 1);
    step(0, 64'h0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 64'h0, 1, 0, 1);

    // Twenty entries streamed across the pointer wrap
    for (int i = 0; i < 20; i++) step(1, 64'h2000 + 64'(4 * i), 1'($urandom_range(0, 1)), 0, 1);
    for (int i = 0; i < 24; i++) step(0, 64'h0, 1, 0, 1);

    // Reset while holding seven entries
    for (int i = 0; i < 7; i++) step(1, 64'h5000 + 64'(4 * i), 0, 0, 1);
    step(0, 64'h0, 1, 1, 0);
    step(0, 64'h0, 0, 0, 1);

    // Random traffic with occasional redirects and resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 64'h8000 + 64'(4 * i), ($urandom % 3) != 0,
           ($urandom % 40) == 0, ($urandom % 97) != 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 64'h0, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
